cpu_ram_loader: RTL and testbench
=================================

CPU_RAM_LOADER -- requirements
Module: cpu_ram_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: single-cycle pulse that begins a transfer; sampled only in IDLE.
REQ-004 SHALL have port mode, input, 1 bit: 0 = load (stream to RAM), 1 = readback (RAM to stream); sampled with start.
REQ-005 SHALL have port base_address, input, 13 bits: first 16-bit RAM word address; sampled with start.
REQ-006 SHALL have port length, input, 14 bits: word count, 0..8192; sampled with start.
REQ-007 SHALL have port abort, input, 1 bit: terminates the transfer in progress.
REQ-008 SHALL have ports s_valid (in, 1), s_data (in, 16) and s_ready (out, 1): load-stream valid/ready handshake.
REQ-009 SHALL have ports m_valid (out, 1), m_data (out, 16) and m_ready (in, 1): readback-stream valid/ready handshake.
REQ-010 SHALL have ports ram_write (out, 1), ram_address (out, 13), ram_wdata (out, 16) and ram_rdata (in, 16), mapped one-to-one onto the if_cpu_ram external modport.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port checksum, output, 16 bits: running sum of transferred words.

Function
REQ-014 SHALL implement the states IDLE, LOAD, RD_ADDR, RD_DATA, RD_OUT and FINISH.
REQ-015 SHALL, in IDLE, act on start: clear count and checksum, latch mode, base_address and length, then go to FINISH if length=0, else to LOAD (mode=0) or RD_ADDR (mode=1).
REQ-016 SHALL ignore start in every state other than IDLE.
REQ-017 SHALL drive s_ready=1 only in LOAD; m_valid=1 only in RD_OUT.
REQ-018 SHALL, on a LOAD handshake (s_valid && s_ready), register for exactly the next cycle: ram_write=1, ram_address=(base+count) mod 8192, ram_wdata=s_data.
REQ-019 SHALL, on each LOAD handshake, increment count and add s_data to checksum; sustained s_valid SHALL give one write per cycle.
REQ-020 SHALL leave LOAD for FINISH on the handshake that brings count to length.
REQ-021 SHALL, in RD_ADDR, hold ram_address=(base+count) mod 8192 (registered on entry) and then go to RD_DATA.
REQ-022 SHALL, in RD_DATA, keep ram_address unchanged, capture ram_rdata into m_data, add it to checksum and go to RD_OUT.
REQ-023 SHALL, in RD_OUT, hold m_data stable until m_valid && m_ready, then increment count and go to FINISH if count equals length, else to RD_ADDR.
REQ-024 SHALL keep ram_write=0 in every readback state.
REQ-025 SHALL take address arithmetic modulo 8192, so 0x1FFF wraps to 0x0000.
REQ-026 SHALL take checksum arithmetic modulo 65536 with overflow discarded.
REQ-027 SHALL, in FINISH, assert done for one cycle, then return to IDLE; in load mode done SHALL fall in the cycle after the final ram_write pulse.
REQ-028 SHALL, on abort in any non-IDLE state, go to IDLE next cycle: no done, no further ram_write beyond one already registered, and m_valid and s_ready deasserted.
REQ-029 SHALL give abort precedence over a handshake occurring in the same cycle; that word SHALL not be counted or checksummed.
REQ-030 SHALL hold checksum stable from done until the next accepted start.

Reset
REQ-031 SHALL, while reset_n=0 (asynchronously), set state=IDLE, ram_write=0, ram_address=0, ram_wdata=0, s_ready=0, m_valid=0, m_data=0, busy=0, done=0, checksum=0 and count=0.
REQ-032 SHALL, on reset mid-transfer, abandon the transfer with no done pulse and perform no RAM write from the first cycle of reset.

Verification
REQ-033 SHALL cover: load, base 0x0010, length 4, data 0x1111/0x2222/0x3333/0x4444 back-to-back -> writes at 0x0010..0x0013 in consecutive cycles, checksum 0xAAAA, done next cycle.
REQ-034 SHALL cover: load, base 0x1FFF, length 2, data 0xFFFF/0x0002 -> writes at 0x1FFF then 0x0000, checksum 0x0001.
REQ-035 SHALL cover: length 0, either mode -> done one cycle after start, no ram_write, no stream handshake, checksum 0x0000.
REQ-036 SHALL cover: readback of the REQ-033 data with m_ready low for 3 cycles on the second word -> m_data 0x1111..0x4444 in order, held stable while stalled, checksum 0xAAAA.
REQ-037 SHALL cover: abort after 2 of 4 load words, with s_valid high during abort -> at most 2 writes, no done, busy low next cycle, and start accepted again.
REQ-038 SHALL cover: reset_n low during RD_OUT -> all outputs at their reset values immediately, then a new transfer completes normally.

Source files
------------

// File: rtl/cpu_ram_loader_if.sv
// Stream and RAM bundle for cpu_ram_loader; master = loader side, slave = RAM/stream environment.
// Combinational wiring only; handshake semantics live in the loader.
interface cpu_ram_loader_if;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic        ram_write;
    logic [12:0] ram_address;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    modport master (
        input  s_valid, s_data, m_ready, ram_rdata,
        output s_ready, m_valid, m_data, ram_write, ram_address, ram_wdata
    );

    modport slave (
        output s_valid, s_data, m_ready, ram_rdata,
        input  s_ready, m_valid, m_data, ram_write, ram_address, ram_wdata
    );
endinterface

// File: rtl/cpu_ram_loader.sv
// Moves words between a valid/ready stream and an 8K x 16 RAM, keeping a 16-bit running sum.
// Load: one registered write per accepted word; readback: 3 cycles/word, m_data held while m_ready low.
module cpu_ram_loader (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [12:0]      base_address,
    input  logic [13:0]      length,
    input  logic             abort,
    cpu_ram_loader_if.master bus,
    output logic             busy,
    output logic             done,
    output logic [15:0]      checksum
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] RD_ADDR = 3'd2;
    localparam logic [2:0] RD_DATA = 3'd3;
    localparam logic [2:0] RD_OUT  = 3'd4;
    localparam logic [2:0] FINISH  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [13:0] count_q, count_d;
    logic [15:0] checksum_q, checksum_d;
    logic [12:0] base_q, base_d;
    logic [13:0] length_q, length_d;
    logic        ram_write_q, ram_write_d;
    logic [12:0] ram_address_q, ram_address_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic [15:0] m_data_q, m_data_d;

    logic [13:0] count_inc;
    logic [12:0] addr_cur;
    logic [12:0] addr_nxt;

    assign count_inc = count_q + 14'd1;
    // 13-bit adders give the modulo-8192 wrap for free
    assign addr_cur  = base_q + count_q[12:0];
    assign addr_nxt  = base_q + count_inc[12:0];

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        checksum_d    = checksum_q;
        base_d        = base_q;
        length_d      = length_q;
        ram_write_d   = 1'b0;
        ram_address_d = ram_address_q;
        ram_wdata_d   = ram_wdata_q;
        m_data_d      = m_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d    = 14'd0;
                    checksum_d = 16'd0;
                    base_d     = base_address;
                    length_d   = length;
                    if (length == 14'd0) begin
                        state_d = FINISH;
                    end else if (mode) begin
                        state_d       = RD_ADDR;
                        ram_address_d = base_address;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                // abort wins over a same-cycle handshake: the word is dropped
                if (abort) begin
                    state_d = IDLE;
                end else if (bus.s_valid) begin
                    ram_write_d   = 1'b1;
                    ram_address_d = addr_cur;
                    ram_wdata_d   = bus.s_data;
                    count_d       = count_inc;
                    checksum_d    = checksum_q + bus.s_data;
                    if (count_inc == length_q) begin
                        state_d = FINISH;
                    end
                end
            end
            RD_ADDR: begin
                state_d = abort ? IDLE : RD_DATA;
            end
            RD_DATA: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    m_data_d   = bus.ram_rdata;
                    checksum_d = checksum_q + bus.ram_rdata;
                    state_d    = RD_OUT;
                end
            end
            RD_OUT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bus.m_ready) begin
                    count_d = count_inc;
                    if (count_inc == length_q) begin
                        state_d = FINISH;
                    end else begin
                        state_d       = RD_ADDR;
                        ram_address_d = addr_nxt;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            count_q       <= 14'd0;
            checksum_q    <= 16'd0;
            base_q        <= 13'd0;
            length_q      <= 14'd0;
            ram_write_q   <= 1'b0;
            ram_address_q <= 13'd0;
            ram_wdata_q   <= 16'd0;
            m_data_q      <= 16'd0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            checksum_q    <= checksum_d;
            base_q        <= base_d;
            length_q      <= length_d;
            ram_write_q   <= ram_write_d;
            ram_address_q <= ram_address_d;
            ram_wdata_q   <= ram_wdata_d;
            m_data_q      <= m_data_d;
        end
    end

    assign bus.s_ready     = (state_q == LOAD);
    assign bus.m_valid     = (state_q == RD_OUT);
    assign bus.m_data      = m_data_q;
    assign bus.ram_write   = ram_write_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_wdata   = ram_wdata_q;

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign checksum = checksum_q;

endmodule

// File: tb/tb_cpu_ram_loader.sv
// Randomized scoreboard bench for cpu_ram_loader with a behavioural RAM and array-based reference model.
module tb_cpu_ram_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [12:0] base_address;
    logic [13:0] length;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    cpu_ram_loader_if bus();

    cpu_ram_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .mode         (mode),
        .base_address (base_address),
        .length       (length),
        .abort        (abort),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    logic [15:0] ram_mem [0:8191];
    logic [15:0] ref_mem [0:8191];

    always @(posedge clk) begin
        if (bus.ram_write) ram_mem[bus.ram_address] <= bus.ram_wdata;
        bus.ram_rdata <= ram_mem[bus.ram_address];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [12:0] exp_wa [$];
    logic [15:0] exp_wd [$];
    logic [15:0] exp_rd [$];
    logic [15:0] exp_ck [$];
    logic [15:0] load_data [$];
    int          wr_cycs [$];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          stream_cnt = 0;
    int          start_cyc = 0;
    logic [15:0] last_ck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write, a stream word or done
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.ram_write) begin
                wr_cnt++;
                wr_cycs.push_back(cyc);
                if (exp_wa.size() == 0) chk("unexpected_ram_write", 32'd1, 32'd0);
                else begin
                    chk("wr_addr", 32'(bus.ram_address), 32'(exp_wa.pop_front()));
                    chk("wr_data", 32'(bus.ram_wdata), 32'(exp_wd.pop_front()));
                end
            end
            if (bus.s_ready || bus.m_valid) stream_cnt++;
            if (bus.m_valid) begin
                if (exp_rd.size() == 0) chk("unexpected_m_valid", 32'd1, 32'd0);
                else begin
                    chk("m_data", 32'(bus.m_data), 32'(exp_rd[0]));
                    if (bus.m_ready) void'(exp_rd.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_ck.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else chk("checksum_at_done", 32'(checksum), 32'(exp_ck.pop_front()));
            end
            if (!busy) chk("idle_stream_outputs", {30'd0, bus.s_ready, bus.m_valid}, 32'd0);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},     32'(busy), 32'd0);
        chk({tag, "_done"},     32'(done), 32'd0);
        chk({tag, "_checksum"}, 32'(checksum), 32'd0);
        chk({tag, "_s_ready"},  32'(bus.s_ready), 32'd0);
        chk({tag, "_m_valid"},  32'(bus.m_valid), 32'd0);
        chk({tag, "_m_data"},   32'(bus.m_data), 32'd0);
        chk({tag, "_ram_write"}, 32'(bus.ram_write), 32'd0);
        chk({tag, "_ram_addr"}, 32'(bus.ram_address), 32'd0);
        chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'd0);
    endtask

    task automatic pulse_start(input logic m, input logic [12:0] b, input int len);
        int t = 0;
        while (busy && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("start_wait_idle", 32'(busy), 32'd0);
        start = 1'b1;
        mode = m;
        base_address = b;
        length = 14'(len);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'($urandom);
        base_address = 13'($urandom);
        length = 14'($urandom);
    endtask

    task automatic finish_xfer(input bit expect_done);
        int t = 0;
        while (busy && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        chk("xfer_returns_idle", 32'(busy), 32'd0);
        chk("wr_queue_empty", 32'(exp_wa.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_ck.size()), 32'd0);
        if (expect_done) begin
            repeat (3) begin
                @(posedge clk); #1;
            end
            chk("checksum_hold", 32'(checksum), 32'(last_ck));
        end
    endtask

    task automatic run_load(input logic [12:0] base, input int len, input bit b2b, input int abort_at);
        int n_ok;
        int sum = 0;
        int ai;
        n_ok = (abort_at >= 0) ? abort_at : len;
        for (int i = 0; i < n_ok; i++) begin
            ai = (int'(base) + i) % 8192;
            exp_wa.push_back(ai[12:0]);
            exp_wd.push_back(load_data[i]);
            ref_mem[ai] = load_data[i];
            sum = (sum + int'(load_data[i])) % 65536;
        end
        if (abort_at < 0) begin
            exp_ck.push_back(sum[15:0]);
            last_ck = sum[15:0];
        end
        pulse_start(1'b0, base, len);
        for (int i = 0; i < len; i++) begin
            int t = 0;
            if (i == abort_at) begin
                bus.s_valid = 1'b1;
                bus.s_data = 16'($urandom);
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                bus.s_valid = 1'b0;
                chk("busy_after_abort", 32'(busy), 32'd0);
                break;
            end
            if (!b2b) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data = load_data[i];
            while (!bus.s_ready && t < 200) begin
                @(posedge clk); #1; t++;
            end
            chk("s_ready_wait", 32'(t < 200), 32'd1);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        finish_xfer(abort_at < 0);
    endtask

    task automatic run_read(input logic [12:0] base, input int len, input int stall_word);
        int sum = 0;
        int ai;
        int hs = 0;
        int stall_left = 3;
        int t = 0;
        for (int i = 0; i < len; i++) begin
            ai = (int'(base) + i) % 8192;
            exp_rd.push_back(ref_mem[ai]);
            sum = (sum + int'(ref_mem[ai])) % 65536;
        end
        exp_ck.push_back(sum[15:0]);
        last_ck = sum[15:0];
        pulse_start(1'b1, base, len);
        while (busy && t < 5000) begin
            if (bus.m_valid && hs == stall_word && stall_left > 0) begin
                bus.m_ready = 1'b0;
                stall_left--;
            end else if (stall_word < 0) begin
                bus.m_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.m_ready = 1'b1;
            end
            if (bus.m_valid && bus.m_ready) hs++;
            @(posedge clk); #1; t++;
        end
        bus.m_ready = 1'b1;
        if (stall_word >= 0) chk("rd_stall_applied", 32'(stall_left), 32'd0);
        finish_xfer(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int wr0, done0, str0;
        for (int i = 0; i < 8192; i++) begin
            ram_mem[i] = 16'd0;
            ref_mem[i] = 16'd0;
        end
        reset_n = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        base_address = 13'd0;
        length = 14'd0;
        abort = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = 16'd0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back load, 4 words
        load_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        wr_cycs.delete();
        run_load(13'h0010, 4, 1'b1, -1);
        chk("b2b_write_count", 32'(wr_cycs.size()), 32'd4);
        if (wr_cycs.size() == 4) begin
            chk("b2b_consecutive", 32'(wr_cycs[3] - wr_cycs[0]), 32'd3);
            chk("done_with_last_write", 32'(done_cyc), 32'(wr_cycs[3]));
        end
        chk("checksum_aaaa", 32'(checksum), 32'h0000AAAA);

        // address wrap at the top of RAM
        load_data = '{16'hFFFF, 16'h0002};
        run_load(13'h1FFF, 2, 1'b1, -1);
        chk("checksum_wrap", 32'(checksum), 32'h00000001);

        // zero-length transfers in both modes
        for (int m = 0; m < 2; m++) begin
            wr0 = wr_cnt;
            str0 = stream_cnt;
            if (m == 0) run_load(13'h0123, 0, 1'b1, -1);
            else run_read(13'h0123, 0, -1);
            chk("len0_no_write", 32'(wr_cnt - wr0), 32'd0);
            chk("len0_no_stream", 32'(stream_cnt - str0), 32'd0);
            chk("len0_done_latency", 32'(done_cyc), 32'(start_cyc + 1));
            chk("len0_checksum", 32'(checksum), 32'd0);
        end

        // readback with a 3-cycle stall on the second word
        run_read(13'h0010, 4, 1);
        chk("readback_checksum", 32'(checksum), 32'h0000AAAA);

        // abort after two words with s_valid still high
        load_data = '{16'hA5A5, 16'h0F0F, 16'h1234, 16'h4321};
        wr0 = wr_cnt;
        done0 = done_cnt;
        run_load(13'h0200, 4, 1'b1, 2);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("abort_writes", 32'(wr_cnt - wr0), 32'd2);
        chk("abort_no_done", 32'(done_cnt - done0), 32'd0);
        load_data = '{16'h0001, 16'h0002, 16'h0003};
        run_load(13'h0300, 3, 1'b0, -1);
        chk("restart_after_abort", 32'(checksum), 32'h00000006);

        // reset while a word is waiting in RD_OUT
        for (int i = 0; i < 4; i++) exp_rd.push_back(ref_mem[16 + i]);
        exp_ck.push_back(16'hAAAA);
        pulse_start(1'b1, 13'h0010, 4);
        bus.m_ready = 1'b0;
        begin
            int t = 0;
            while (!bus.m_valid && t < 50) begin
                @(posedge clk); #1; t++;
            end
        end
        chk("reach_rd_out", 32'(bus.m_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        exp_rd.delete();
        exp_ck.delete();
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_reset_vals("held_reset");
        reset_n = 1'b1;
        bus.m_ready = 1'b1;
        run_read(13'h0010, 4, -1);
        chk("post_reset_checksum", 32'(checksum), 32'h0000AAAA);

        // randomized mix of loads and readbacks
        for (int k = 0; k < 14; k++) begin
            logic [12:0] b;
            int len;
            b = 13'($urandom);
            if (k % 3 == 0) b = 13'h1FF0 + 13'($urandom_range(0, 15));
            len = $urandom_range(0, 24);
            if ($urandom_range(0, 1) == 0) begin
                load_data.delete();
                for (int i = 0; i < len; i++) load_data.push_back(16'($urandom));
                run_load(b, len, 1'($urandom), -1);
            end else begin
                run_read(b, len, -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
